part_compare: RTL and testbench

PART_COMPARE -- requirements
Module: part_compare

---
 rtl/part_pkg.sv | 15 +
 rtl/abs_dev_cmp.sv | 20 ++
 rtl/part_compare.sv | 185 ++++++++++++++++++
 tb/tb_part_compare.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/part_pkg.sv
// Shared constants and FSM encoding for the part profile compare/memorize blocks.
package part_pkg;

    localparam int unsigned DATA_W        = 12;
    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned BUFFER_LENGTH = 882;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PART = 2'd1,
        COMPARE   = 2'd2,
        FINISH    = 2'd3
    } state_e;

endpackage

// File: rtl/abs_dev_cmp.sv
// Unsigned absolute difference of two samples plus a tolerance check.
module abs_dev_cmp
    import part_pkg::*;
#(
    parameter int unsigned TOL = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] dev,
    output logic              over_tol
);

    logic [DATA_W:0] diff;

    // One extra bit holds the sign of a-b so the magnitude is always exact
    assign diff     = {1'b0, a} - {1'b0, b};
    assign dev      = diff[DATA_W] ? DATA_W'(-diff) : diff[DATA_W-1:0];
    assign over_tol = 32'(dev) > TOL;

endmodule

// File: rtl/part_compare.sv
// Compares a live CCD width profile against a stored profile and reports a verdict.
// Optional PART_COMPARE_MAXDEV_EN adds tracking of the largest per-sample deviation.
module part_compare
    import part_pkg::*;
#(
    parameter int unsigned TOL          = 4,
    parameter int unsigned MAX_MISMATCH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] part_len,
    input  logic [DATA_W-1:0] ccd_data,
    input  logic              ccd_data_valid,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rden,
    output logic              ccd_enable,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              length_err,
    output logic [ADDR_W-1:0] mismatch_cnt,
    output logic [DATA_W-1:0] max_dev
);

    localparam logic [DATA_W-1:0] TERM_SAMPLE = DATA_W'(BUFFER_LENGTH);
    localparam logic [ADDR_W-1:0] CNT_MAX     = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [ADDR_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic              mem_rden_q, mem_rden_d;
    logic              ccd_enable_q, ccd_enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              length_err_q, length_err_d;
    logic              over_q, over_d;
    logic              count_mis;

    logic [DATA_W-1:0] dev;
    logic              over_tol;
    logic              sample_c;
    logic              term_c;
    logic              consume_c;

    abs_dev_cmp #(.TOL(TOL)) u_abs_dev_cmp (
        .a        (ccd_data),
        .b        (mem_q),
        .dev      (dev),
        .over_tol (over_tol)
    );

    assign sample_c  = ccd_data_valid && (ccd_data != TERM_SAMPLE) && (ccd_data != '0);
    assign term_c    = ccd_data_valid && (ccd_data == TERM_SAMPLE);
    assign consume_c = sample_c && ((state_q == WAIT_PART) || (state_q == COMPARE));

    // over_q marks that entry part_len was consumed, so any further sample is an overrun
    always_comb begin
        state_d        = state_q;
        mem_address_d  = mem_address_q;
        mismatch_cnt_d = mismatch_cnt_q;
        mem_rden_d     = mem_rden_q;
        ccd_enable_d   = ccd_enable_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pass_d         = pass_q;
        length_err_d   = length_err_q;
        over_d         = over_q;
        count_mis      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mismatch_cnt_d = '0;
                    pass_d         = 1'b0;
                    busy_d         = 1'b1;
                    over_d         = 1'b0;
                    if (part_len == '0) begin
                        length_err_d = 1'b1;
                        state_d      = FINISH;
                    end else begin
                        length_err_d  = 1'b0;
                        mem_address_d = ADDR_W'(1);
                        mem_rden_d    = 1'b1;
                        ccd_enable_d  = 1'b1;
                        state_d       = WAIT_PART;
                    end
                end
            end
            WAIT_PART: begin
                if (sample_c) state_d = COMPARE;
            end
            COMPARE: begin
                if (term_c) begin
                    if (!over_q) length_err_d = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                pass_d       = !length_err_q && (32'(mismatch_cnt_q) <= MAX_MISMATCH);
                done_d       = 1'b1;
                ccd_enable_d = 1'b0;
                mem_rden_d   = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (consume_c) begin
            if (over_q) begin
                length_err_d = 1'b1;
                count_mis    = 1'b1;
            end else begin
                count_mis = over_tol;
                if (mem_address_q == part_len) over_d = 1'b1;
                else mem_address_d = mem_address_q + ADDR_W'(1);
            end
        end

        if (count_mis && (mismatch_cnt_q != CNT_MAX))
            mismatch_cnt_d = mismatch_cnt_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mem_address_q  <= '0;
            mismatch_cnt_q <= '0;
            mem_rden_q     <= 1'b0;
            ccd_enable_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            length_err_q   <= 1'b0;
            over_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_address_q  <= mem_address_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            mem_rden_q     <= mem_rden_d;
            ccd_enable_q   <= ccd_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            length_err_q   <= length_err_d;
            over_q         <= over_d;
        end
    end

`ifdef PART_COMPARE_MAXDEV_EN
    logic [DATA_W-1:0] max_dev_q, max_dev_d;

    // Overrun samples have no stored entry, so they do not contribute a deviation
    always_comb begin
        max_dev_d = max_dev_q;
        if ((state_q == IDLE) && start) max_dev_d = '0;
        else if (consume_c && !over_q && (dev > max_dev_q)) max_dev_d = dev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) max_dev_q <= '0;
        else        max_dev_q <= max_dev_d;
    end

    assign max_dev = max_dev_q;
`else
    logic dev_unused;

    assign dev_unused = ^dev;
    assign max_dev    = '0;
`endif

    assign mem_address  = mem_address_q;
    assign mem_rden     = mem_rden_q;
    assign ccd_enable   = ccd_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign length_err   = length_err_q;
    assign mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_part_compare.sv
// Directed bench for part_compare: matching, tolerance, length errors, zero skip, reset, empty part.
module tb_part_compare;
    import part_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] part_len;
    logic [DATA_W-1:0] ccd_data;
    logic              ccd_data_valid;
    logic [DATA_W-1:0] mem_q, mem_q_s;
    logic [ADDR_W-1:0] mem_address, mem_address_s;
    logic              mem_rden, mem_rden_s, ccd_enable, ccd_enable_s;
    logic              busy, busy_s, done, done_s, pass, pass_s;
    logic              length_err, length_err_s;
    logic [ADDR_W-1:0] mismatch_cnt, mismatch_cnt_s;
    logic [DATA_W-1:0] max_dev, max_dev_s;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int ccd_en_cnt = 0;
    int over_addr_cnt = 0;

    part_compare u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .part_len(part_len),
        .ccd_data(ccd_data), .ccd_data_valid(ccd_data_valid), .mem_q(mem_q),
        .mem_address(mem_address), .mem_rden(mem_rden), .ccd_enable(ccd_enable),
        .busy(busy), .done(done), .pass(pass), .length_err(length_err),
        .mismatch_cnt(mismatch_cnt), .max_dev(max_dev)
    );

    part_compare #(.MAX_MISMATCH(0)) u_dut_strict (
        .clk(clk), .rst_n(rst_n), .start(start), .part_len(part_len),
        .ccd_data(ccd_data), .ccd_data_valid(ccd_data_valid), .mem_q(mem_q_s),
        .mem_address(mem_address_s), .mem_rden(mem_rden_s), .ccd_enable(ccd_enable_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .length_err(length_err_s),
        .mismatch_cnt(mismatch_cnt_s), .max_dev(max_dev_s)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        mem_q   <= mem[mem_address];
        mem_q_s <= mem[mem_address_s];
        if (done) done_cnt <= done_cnt + 1;
        if (ccd_enable) ccd_en_cnt <= ccd_en_cnt + 1;
        if (busy && (mem_address > part_len)) over_addr_cnt <= over_addr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int v);
        ccd_data       = DATA_W'(v);
        ccd_data_valid = 1'b1;
        tick();
        ccd_data_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_all(input int q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t = 0;
        while ((done_cnt == d0) && (t < 20)) begin
            tick();
            t++;
        end
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    int d0, e0, o0;
`ifdef PART_COMPARE_MAXDEV_EN
    localparam bit MAXDEV = 1'b1;
`else
    localparam bit MAXDEV = 1'b0;
`endif

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[1] = 12'd100; mem[2] = 12'd200; mem[3] = 12'd300; mem[4] = 12'd400; mem[5] = 12'd500;
        rst_n = 1'b1; start = 1'b0; part_len = 10'd5; ccd_data = '0; ccd_data_valid = 1'b0;
        #3 rst_n = 1'b0;
        #4;
        check("rst_busy", busy, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_ccd_enable", ccd_enable, 0);
        check("rst_pass", pass, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Matching run
        d0 = done_cnt;
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_mem_address", mem_address, 1);
        check("t1_ccd_enable", ccd_enable, 1);
        send_all('{882, 882, 100, 203, 300, 396, 500, 882});
        wait_done("t1", d0);
        check("t1_pass", pass, 1);
        check("t1_mismatch", mismatch_cnt, 0);
        check("t1_length_err", length_err, 0);
        check("t1_max_dev", max_dev, MAXDEV ? 4 : 0);
        check("t1_ccd_enable_off", ccd_enable, 0);

        // Tolerance edge: one sample 5 away
        d0 = done_cnt;
        pulse_start();
        send_all('{882, 105, 200, 300, 400, 500, 882});
        wait_done("t2", d0);
        check("t2_mismatch", mismatch_cnt, 1);
        check("t2_pass", pass, 1);
        check("t2_strict_mismatch", mismatch_cnt_s, 1);
        check("t2_strict_pass", pass_s, 0);
        check("t2_max_dev", max_dev, MAXDEV ? 5 : 0);

        // Short part
        d0 = done_cnt;
        pulse_start();
        send_all('{882, 100, 200, 300, 882});
        wait_done("t3", d0);
        check("t3_length_err", length_err, 1);
        check("t3_pass", pass, 0);
        check("t3_mismatch", mismatch_cnt, 0);

        // Long part
        d0 = done_cnt;
        o0 = over_addr_cnt;
        pulse_start();
        send_all('{882, 100, 200, 300, 400, 500, 600, 700, 882});
        wait_done("t4", d0);
        check("t4_length_err", length_err, 1);
        check("t4_mismatch", mismatch_cnt, 2);
        check("t4_pass", pass, 0);
        check("t4_mem_address", mem_address, 5);
        check("t4_addr_overrun_cycles", over_addr_cnt - o0, 0);

        // Zero skip and start rejection
        d0 = done_cnt;
        pulse_start();
        send_all('{882, 100});
        check("t5_addr_after_100", mem_address, 2);
        send(0);
        check("t5_addr_after_zero", mem_address, 2);
        send(210);
        check("t5_mismatch_after_210", mismatch_cnt, 1);
        pulse_start();
        check("t5_busy_start_ignored", busy, 1);
        check("t5_mismatch_start_ignored", mismatch_cnt, 1);
        check("t5_addr_start_ignored", mem_address, 3);
        send_all('{0, 300, 0, 400, 500, 882});
        wait_done("t5", d0);
        check("t5_mismatch", mismatch_cnt, 1);
        check("t5_pass", pass, 1);
        check("t5_length_err", length_err, 0);

        // Reset mid-compare
        d0 = done_cnt;
        pulse_start();
        send_all('{882, 100, 200});
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_mem_address", mem_address, 0);
        check("t6_mem_rden", mem_rden, 0);
        check("t6_ccd_enable", ccd_enable, 0);
        check("t6_pass", pass, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();
        check("t6_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        pulse_start();
        send_all('{882, 100, 200, 300, 400, 500, 882});
        wait_done("t6b", d0);
        check("t6b_pass", pass, 1);
        check("t6b_mismatch", mismatch_cnt, 0);

        // Empty stored profile
        part_len = '0;
        tick();
        d0 = done_cnt;
        e0 = ccd_en_cnt;
        pulse_start();
        check("t7_done_early", done, 0);
        tick();
        check("t7_done", done, 1);
        check("t7_length_err", length_err, 1);
        check("t7_pass", pass, 0);
        repeat (3) tick();
        check("t7_done_pulses", done_cnt - d0, 1);
        check("t7_ccd_enable_cycles", ccd_en_cnt - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
